// File: rtl/instruction_fetch_unit_pkg.sv
// Shared pipeline definitions used by the fetch stage: the NOP encoding,
// the fetch FSM state type and small PC helpers.
package instruction_fetch_unit_pkg;

  // Canonical NOP (addi x0, x0, 0) used to fill empty pipeline registers.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Fetch FSM state type; encodings kept as plain constants so existing
  // waveform decoders and debug scripts keep working.
  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t FETCH_REQ   = 2'd0;  // request the word at pc
  localparam fetch_state_t FETCH_WAIT  = 2'd1;  // granted, waiting for data
  localparam fetch_state_t FETCH_DRAIN = 2'd2;  // waiting to drop a stale response

  // Next sequential fetch address; wraps modulo 2^32.
  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Force a word-aligned address.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_skid_buffer.sv
// One-entry output register between instruction fetch and the IF/ID stage.
// Holds an {instruction, pc} pair until the decode side accepts it.
module fetch_skid_buffer
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,       // drop the held pair (redirect)
  input  logic        load,        // capture a new pair
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  input  logic        ready,       // downstream accepts this cycle
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        free         // empty, or emptying this cycle
);

  // Entry state: flush beats load, load beats a plain transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc    <= RESET_PC;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

  assign free = !valid || ready;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: walks the PC, issues one instruction-memory
// request at a time, and hands {instruction, pc} pairs to the IF/ID stage.
// A redirect from a later stage replaces the PC, empties the output entry
// and causes any in-flight response to be dropped.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // instruction memory
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  // redirect from a later stage
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  // IF/ID handshake
  output logic [31:0] f_instruction_o,
  output logic [31:0] f_pcsrc_o,
  output logic        f_valid_o,
  input  logic        d_ready_i
);

  localparam logic [31:0] RESET_PC_ALIGNED = align_pc(RESET_PC);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic         buf_free;
  logic         req_fire;
  logic         rsp_take;

  // pc is not advanced until the response returns, so while in FETCH_WAIT
  // it still names the outstanding request and doubles as the pending PC.
  assign imem_req_o  = !rst_i && (state == FETCH_REQ) && buf_free;
  assign imem_addr_o = pc;
  assign req_fire    = imem_req_o && imem_gnt_i;
  assign rsp_take    = (state == FETCH_WAIT) && imem_rvalid_i && !redirect_i;

  // Next-state and next-PC selection; a redirect overrides the PC in every state.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      FETCH_REQ: begin
        if (req_fire) begin
          state_nxt = redirect_i ? FETCH_DRAIN : FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (imem_rvalid_i) begin
          state_nxt = FETCH_REQ;
          if (!redirect_i) begin
            pc_nxt = pc_incr(pc);
          end
        end else if (redirect_i) begin
          state_nxt = FETCH_DRAIN;
        end
      end
      FETCH_DRAIN: begin
        if (imem_rvalid_i) begin
          state_nxt = FETCH_REQ;
        end
      end
      default: state_nxt = FETCH_REQ;
    endcase
    if (redirect_i) begin
      pc_nxt = align_pc(redirect_pc_i);
    end
  end

  // FSM and PC registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= FETCH_REQ;
      pc    <= RESET_PC_ALIGNED;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  fetch_skid_buffer #(
    .RESET_PC (RESET_PC)
  ) u_skid (
    .clk        (clk_i),
    .rst        (rst_i),
    .flush      (redirect_i),
    .load       (rsp_take),
    .load_instr (imem_rdata_i),
    .load_pc    (pc),
    .ready      (d_ready_i),
    .valid      (f_valid_o),
    .instr      (f_instruction_o),
    .pc         (f_pcsrc_o),
    .free       (buf_free)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a behavioural memory answers
// requests, the driver pushes the expected instruction stream whenever it
// (re)starts fetch, and a monitor pops and compares every IF/ID transfer.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk_i;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] f_instruction_o;
  logic [31:0] f_pcsrc_o;
  logic        f_valid_o;
  logic        d_ready_i;

  instruction_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .f_instruction_o (f_instruction_o),
    .f_pcsrc_o       (f_pcsrc_o),
    .f_valid_o       (f_valid_o),
    .d_ready_i       (d_ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Memory contents: every address holds a distinct word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } pair_t;

  pair_t exp_q[$];
  pair_t stage_q[$];
  bit    stage_pending = 0;

  // Reference model: after a (re)start at address A, the decode side must see
  // exactly mem[A], mem[A+4], ... in order; everything older is discarded.
  task automatic stage_stream(input logic [31:0] start);
    logic [31:0] p;
    p = {start[31:2], 2'b00};
    stage_q.delete();
    for (int i = 0; i < 128; i++) begin
      stage_q.push_back('{pc: p, instr: mem_word(p)});
      p = p + 32'd4;
    end
    stage_pending = 1;
  endtask

  // ---------------- memory model ----------------
  int unsigned gnt_pct = 100;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  int unsigned gnt_count = 0;
  bit          mem_busy = 0;
  logic [31:0] mem_addr_q = '0;
  int unsigned lat_left = 0;
  bit          prev_req_hold = 0;
  logic [31:0] prev_req_addr = '0;

  always @(negedge clk_i) begin : memory
    bit busy;
    if (rst_i) begin
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      mem_busy      = 0;
      prev_req_hold = 0;
    end else begin
      busy = mem_busy;
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
      if (prev_req_hold) begin
        check("req_held", 32'(imem_req_o), 32'd1);
        check("addr_held", imem_addr_o, prev_req_addr);
      end
      if (mem_busy) begin
        if (lat_left == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = mem_word(mem_addr_q);
          mem_busy      = 0;
        end else begin
          lat_left--;
        end
      end
      if (imem_req_o) begin
        check("addr_align", 32'(imem_addr_o[1:0]), 32'd0);
        check("one_outstanding", 32'(busy), 32'd0);
        if (!busy && ($urandom_range(99) < gnt_pct)) begin
          imem_gnt_i = 1'b1;
          mem_busy   = 1;
          mem_addr_q = imem_addr_o;
          lat_left   = $urandom_range(lat_max, lat_min) - 1;
          gnt_count++;
        end
      end
      prev_req_hold = imem_req_o && !imem_gnt_i && !redirect_i;
      prev_req_addr = imem_addr_o;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int unsigned cyc = 0;
  int unsigned rel_cyc = 0;
  int unsigned xfer_cyc[$];
  bit          prev_redir = 0;
  bit          prev_rst = 0;

  always @(negedge clk_i) begin : monitor
    pair_t e;
    cyc++;
    if (rst_i) begin
      prev_redir = 0;
      xfer_cyc.delete();
      if (stage_pending) begin
        exp_q = stage_q;
        stage_pending = 0;
      end
    end else begin
      if (prev_rst) rel_cyc = cyc;
      if (prev_redir) check("valid_after_redirect", 32'(f_valid_o), 32'd0);
      if (f_valid_o && !d_ready_i) check("req_while_full", 32'(imem_req_o), 32'd0);
      if (f_valid_o && d_ready_i) begin
        xfer_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_pair");
        end else begin
          e = exp_q.pop_front();
          check("pair_pc", f_pcsrc_o, e.pc);
          check("pair_instr", f_instruction_o, e.instr);
        end
      end
      if (redirect_i && stage_pending) begin
        exp_q = stage_q;
        stage_pending = 0;
      end
      prev_redir = redirect_i;
    end
    prev_rst = rst_i;
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input bit verify);
    stage_stream(RPC);
    rst_i = 1'b1;
    @(negedge clk_i);
    if (verify) begin
      check("rst_req", 32'(imem_req_o), 32'd0);
      check("rst_valid", 32'(f_valid_o), 32'd0);
      check("rst_instr", f_instruction_o, 32'h0000_0013);
      check("rst_pcsrc", f_pcsrc_o, RPC);
    end
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    if (verify) begin
      check("first_req", 32'(imem_req_o), 32'd1);
      check("first_addr", imem_addr_o, RPC);
      check("first_valid", 32'(f_valid_o), 32'd0);
    end
  endtask

  task automatic redirect_to(input logic [31:0] target);
    stage_stream(target);
    redirect_i    = 1'b1;
    redirect_pc_i = target;
    tick();
    redirect_i    = 1'b0;
    redirect_pc_i = $urandom;
  endtask

  task automatic wait_grant(output bit ok);
    int unsigned n0;
    n0 = gnt_count;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (gnt_count != n0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("grant_timeout");
  endtask

  initial begin : driver
    bit          ok;
    bit          found;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    int unsigned since_redir;

    rst_i         = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    d_ready_i     = 1'b1;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;

    // Reset and first request.
    tick();
    do_reset(1);

    // Streaming with single-cycle grant/response: one pair every 2 cycles.
    for (int i = 0; i < 12; i++) tick();
    check("stream_count_ok", 32'(xfer_cyc.size() >= 3), 32'd1);
    if (xfer_cyc.size() >= 3) begin
      check("first_latency", xfer_cyc[0] - rel_cyc, 32'd2);
      check("stream_gap0", xfer_cyc[1] - xfer_cyc[0], 32'd2);
      check("stream_gap1", xfer_cyc[2] - xfer_cyc[1], 32'd2);
    end

    // Backpressure: full buffer held for 5 cycles, no requests.
    d_ready_i = 1'b0;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (f_valid_o) begin
        found = 1;
        break;
      end
    end
    if (!found) fail_now("bp_valid_timeout");
    hold_pc    = f_pcsrc_o;
    hold_instr = f_instruction_o;
    for (int k = 0; k < 5; k++) begin
      if (k != 0) @(negedge clk_i);
      check("bp_valid", 32'(f_valid_o), 32'd1);
      check("bp_pc", f_pcsrc_o, hold_pc);
      check("bp_instr", f_instruction_o, hold_instr);
      check("bp_req", 32'(imem_req_o), 32'd0);
    end
    @(posedge clk_i);
    #1;
    d_ready_i = 1'b1;
    @(negedge clk_i);
    check("resume_req", 32'(imem_req_o), 32'd1);
    check("resume_addr", imem_addr_o, hold_pc + 32'd4);

    // Redirect while waiting for a slow response.
    tick();
    lat_min = 3;
    lat_max = 3;
    wait_grant(ok);
    redirect_to(32'h0000_0203);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (imem_req_o) begin
        found = 1;
        break;
      end
    end
    if (!found) fail_now("redir_wait_req_timeout");
    check("redir_wait_addr", imem_addr_o, 32'h0000_0200);

    // Redirect in the same cycle as the response, decode ready.
    tick();
    lat_min = 2;
    lat_max = 2;
    wait_grant(ok);
    tick();
    stage_stream(32'h0000_4446);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_4446;
    tick();
    redirect_i = 1'b0;
    @(negedge clk_i);
    check("redir_rv_valid", 32'(f_valid_o), 32'd0);
    check("redir_rv_req", 32'(imem_req_o), 32'd1);
    check("redir_rv_addr", imem_addr_o, 32'h0000_4444);

    // PC wrap at the top of the address space.
    tick();
    lat_min = 1;
    lat_max = 1;
    redirect_to(32'hFFFF_FFF8);
    found = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (imem_req_o && imem_addr_o == 32'hFFFF_FFFC) begin
        found = 1;
        break;
      end
    end
    if (!found) fail_now("wrap_top_timeout");
    found = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (imem_req_o && imem_addr_o != 32'hFFFF_FFFC) begin
        found = 1;
        break;
      end
    end
    if (!found) fail_now("wrap_next_timeout");
    check("wrap_addr", imem_addr_o, 32'h0000_0000);

    // Randomized traffic with redirects and one mid-operation reset.
    tick();
    gnt_pct = 60;
    lat_min = 1;
    lat_max = 4;
    since_redir = 0;
    for (int n = 0; n < 1500; n++) begin
      d_ready_i = ($urandom_range(99) < 70);
      if (n == 700) begin
        do_reset(0);
        tick();
        since_redir = 0;
      end else if ($urandom_range(99) < 4 || since_redir >= 100) begin
        if ($urandom_range(3) == 0)
          redirect_to(32'hFFFF_FFF0 | 32'($urandom_range(15)));
        else
          redirect_to($urandom);
        since_redir = 0;
      end else begin
        tick();
        since_redir++;
      end
    end

    d_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
